boot_ctrl_reqrsp_responder: RTL and testbench



---
 rtl/boot_ctrl_pkg.sv | 37 +++
 rtl/boot_ctrl_wake_pulse.sv | 45 ++++
 rtl/boot_ctrl_reqrsp_responder.sv | 149 ++++++++++++++
 tb/tb_boot_ctrl_reqrsp_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_ctrl_pkg.sv
// Shared constants, state type and helpers for the cluster boot-control reqrsp responder.
// Offsets are relative to the 32-byte window base; every register is 64 bits wide.
package boot_ctrl_pkg;

    localparam logic [4:0] OFF_BOOT_CONTROL = 5'h00;
    localparam logic [4:0] OFF_WAKEUP       = 5'h08;
    localparam logic [4:0] OFF_SCRATCH      = 5'h10;
    localparam logic [4:0] OFF_STATUS       = 5'h18;

    // Encoding of AMONone in the reqrsp amo_op_e type.
    localparam logic [3:0] AMO_NONE = 4'h0;

    localparam int unsigned STATUS_BOOT_CNT_LSB  = 0;
    localparam int unsigned STATUS_WAKE_CNT_LSB  = 16;
    localparam int unsigned STATUS_PULSE_ACT_LSB = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    function automatic logic [31:0] strb_merge32(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/boot_ctrl_wake_pulse.sv
// Per-core software-interrupt pulse generator: lanes are OR-merged while a pulse is
// running and every accepted fire reloads the cycle counter.
module boot_ctrl_wake_pulse #(
    parameter int unsigned NumCores        = 2,
    parameter int unsigned WakePulseCycles = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fire_i,
    input  logic [NumCores-1:0] lanes_i,
    output logic [NumCores-1:0] msip_o,
    output logic                active_o
);

    logic [3:0]          cnt_q, cnt_d;
    logic [NumCores-1:0] lanes_q, lanes_d, merged;

    always_comb begin
        merged  = lanes_q | lanes_i;
        cnt_d   = cnt_q;
        lanes_d = lanes_q;
        // An empty lane mask with no pulse running leaves the generator idle.
        if (fire_i && (merged != '0)) begin
            cnt_d   = 4'(WakePulseCycles);
            lanes_d = merged;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) lanes_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= 4'd0;
            lanes_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end

    assign msip_o   = lanes_q;
    assign active_o = (cnt_q != 4'd0);

endmodule

// File: rtl/boot_ctrl_reqrsp_responder.sv
// Reqrsp slave for the cluster boot-control window: latches the boot entry point,
// pulses per-core msip on WAKEUP, and offers SCRATCH/STATUS registers.
module boot_ctrl_reqrsp_responder
    import boot_ctrl_pkg::*;
#(
    parameter int unsigned          AddrWidth       = 48,
    parameter int unsigned          DataWidth       = 64,
    parameter int unsigned          NumCores        = 2,
    parameter logic [AddrWidth-1:0] BaseAddr        = '0,
    parameter int unsigned          WakePulseCycles = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   q_valid_i,
    output logic                   q_ready_o,
    input  logic [AddrWidth-1:0]   q_addr_i,
    input  logic                   q_write_i,
    input  logic [DataWidth-1:0]   q_data_i,
    input  logic [DataWidth/8-1:0] q_strb_i,
    input  logic [3:0]             q_amo_i,
    output logic                   p_valid_o,
    input  logic                   p_ready_i,
    output logic [DataWidth-1:0]   p_data_o,
    output logic                   p_error_o,
    output logic [31:0]            entry_point_o,
    output logic                   boot_valid_o,
    output logic [NumCores-1:0]    msip_o
);

    // Handshake: a request transfers on q_valid_i && q_ready_o, a response on
    // p_valid_o && p_ready_i; q_ready_o is high only in IDLE, so requests are
    // accepted at most every second cycle and the response is never overwritten.
    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   p_data_q;
    logic                   p_error_q;
    logic [31:0]            entry_q, entry_d;
    logic                   boot_valid_q;
    logic [63:0]            scratch_q, scratch_d;
    logic [15:0]            boot_cnt_q, wake_cnt_q;

    logic [AddrWidth-1:0]   off;
    logic [4:0]             reg_off;
    logic [63:0]            wdata, rdata, status_w;
    logic [7:0]             wstrb;
    logic [NumCores-1:0]    wake_lanes;
    logic                   hs, in_range, req_err, do_write;
    logic                   boot_wr, wake_wr, scratch_wr, pulse_active;
    logic [DataWidth-1:0]   rsp_data;

    always_comb begin
        state_d   = state_q;
        q_ready_o = 1'b0;
        p_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                q_ready_o = 1'b1;
                if (q_valid_i) state_d = RESP;
            end
            RESP: begin
                p_valid_o = 1'b1;
                if (p_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign off      = q_addr_i - BaseAddr;
    assign in_range = (q_addr_i >= BaseAddr) && (off < AddrWidth'(32));
    assign reg_off  = {off[4:3], 3'b000};
    assign wdata    = 64'(q_data_i);
    assign wstrb    = 8'(q_strb_i);

    assign hs       = q_valid_i && q_ready_o;
    assign req_err  = !in_range || (q_amo_i != AMO_NONE) || (q_write_i && (reg_off == OFF_STATUS));
    assign do_write = hs && q_write_i && !req_err;

    assign boot_wr    = do_write && (reg_off == OFF_BOOT_CONTROL) && (wstrb[3:0] != 4'h0);
    assign wake_wr    = do_write && (reg_off == OFF_WAKEUP);
    assign scratch_wr = do_write && (reg_off == OFF_SCRATCH);

    assign entry_d   = strb_merge32(entry_q, wdata[31:0], wstrb[3:0]);
    assign scratch_d = {strb_merge32(scratch_q[63:32], wdata[63:32], wstrb[7:4]),
                        strb_merge32(scratch_q[31:0],  wdata[31:0],  wstrb[3:0])};

    always_comb begin
        wake_lanes = '0;
        for (int i = 0; i < int'(NumCores); i++) begin
            wake_lanes[i] = wdata[i] & wstrb[i/8];
        end
    end

    always_comb begin
        status_w = '0;
        status_w[STATUS_BOOT_CNT_LSB +: 16] = boot_cnt_q;
        status_w[STATUS_WAKE_CNT_LSB +: 16] = wake_cnt_q;
        status_w[STATUS_PULSE_ACT_LSB]      = pulse_active;
        unique case (reg_off)
            OFF_BOOT_CONTROL: rdata = {32'h0, entry_q};
            OFF_SCRATCH:      rdata = scratch_q;
            OFF_STATUS:       rdata = status_w;
            default:          rdata = '0;
        endcase
        rsp_data = (!q_write_i && !req_err) ? DataWidth'(rdata) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            p_data_q     <= '0;
            p_error_q    <= 1'b0;
            entry_q      <= 32'h0;
            boot_valid_q <= 1'b0;
            scratch_q    <= 64'h0;
            boot_cnt_q   <= 16'h0;
            wake_cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                p_data_q  <= rsp_data;
                p_error_q <= req_err;
            end
            if (boot_wr) begin
                entry_q      <= entry_d;
                boot_valid_q <= 1'b1;
                boot_cnt_q   <= sat_inc16(boot_cnt_q);
            end
            if (scratch_wr) scratch_q <= scratch_d;
            if (wake_wr) wake_cnt_q <= sat_inc16(wake_cnt_q);
        end
    end

    boot_ctrl_wake_pulse #(
        .NumCores        (NumCores),
        .WakePulseCycles (WakePulseCycles)
    ) u_wake_pulse (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .fire_i   (wake_wr),
        .lanes_i  (wake_lanes),
        .msip_o   (msip_o),
        .active_o (pulse_active)
    );

    assign p_data_o      = p_data_q;
    assign p_error_o     = p_error_q;
    assign entry_point_o = entry_q;
    assign boot_valid_o  = boot_valid_q;

endmodule

// File: tb/tb_boot_ctrl_reqrsp_responder.sv
// Bench for the boot-control responder: directed scenarios plus a randomized phase
// checked against a register-level model; a second instance uses a 4-cycle pulse.
module tb_boot_ctrl_reqrsp_responder;

    localparam logic [47:0] BASE = 48'h0;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        q_valid_i = 1'b0;
    logic [47:0] q_addr_i = '0;
    logic        q_write_i = 1'b0;
    logic [63:0] q_data_i = '0;
    logic [7:0]  q_strb_i = '0;
    logic [3:0]  q_amo_i = '0;
    logic        p_ready_i = 1'b0;

    logic        q_ready_o, p_valid_o, p_error_o, boot_valid_o;
    logic [63:0] p_data_o;
    logic [31:0] entry_point_o;
    logic [1:0]  msip_o;

    logic        q_ready_b, p_valid_b, p_error_b, boot_valid_b;
    logic [63:0] p_data_b;
    logic [31:0] entry_point_b;
    logic [1:0]  msip_b;

    always #5 clk = ~clk;

    boot_ctrl_reqrsp_responder dut (
        .clk_i(clk), .rst_i(rst_i), .q_valid_i(q_valid_i), .q_ready_o(q_ready_o),
        .q_addr_i(q_addr_i), .q_write_i(q_write_i), .q_data_i(q_data_i), .q_strb_i(q_strb_i),
        .q_amo_i(q_amo_i), .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_data_o(p_data_o),
        .p_error_o(p_error_o), .entry_point_o(entry_point_o), .boot_valid_o(boot_valid_o),
        .msip_o(msip_o)
    );

    boot_ctrl_reqrsp_responder #(.WakePulseCycles(4)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .q_valid_i(q_valid_i), .q_ready_o(q_ready_b),
        .q_addr_i(q_addr_i), .q_write_i(q_write_i), .q_data_i(q_data_i), .q_strb_i(q_strb_i),
        .q_amo_i(q_amo_i), .p_valid_o(p_valid_b), .p_ready_i(p_ready_i), .p_data_o(p_data_b),
        .p_error_o(p_error_b), .entry_point_o(entry_point_b), .boot_valid_o(boot_valid_b),
        .msip_o(msip_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural register contents only.
    logic [31:0] m_entry      = '0;
    logic [63:0] m_scratch    = '0;
    int          m_boot_cnt   = 0;
    int          m_wake_cnt   = 0;
    logic        m_boot_valid = 1'b0;

    logic [1:0]  msip_trace   [8];
    logic [1:0]  msip_b_trace [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Applies one request to the model and returns the response it should produce.
    // With a 1-cycle pulse and at least two cycles between requests, a STATUS read
    // on the main instance can never see a pulse still active.
    task automatic model_access(input logic [47:0] addr, input logic wr, input logic [63:0] data,
                                input logic [7:0] strb, input logic [3:0] amo,
                                output logic [63:0] exp_d, output logic exp_e);
        logic [47:0] off;
        int          reg_n;
        off   = addr - BASE;
        reg_n = int'(off[4:3]);
        exp_e = (addr < BASE) || (off >= 48'd32) || (amo != 4'd0) || (wr && reg_n == 3);
        exp_d = '0;
        if (!exp_e) begin
            if (wr) begin
                if (reg_n == 0 && strb[3:0] != 4'd0) begin
                    for (int b = 0; b < 4; b++) if (strb[b]) m_entry[8*b +: 8] = data[8*b +: 8];
                    m_boot_valid = 1'b1;
                    m_boot_cnt   = (m_boot_cnt < 65535) ? m_boot_cnt + 1 : 65535;
                end else if (reg_n == 1) begin
                    m_wake_cnt = (m_wake_cnt < 65535) ? m_wake_cnt + 1 : 65535;
                end else if (reg_n == 2) begin
                    for (int b = 0; b < 8; b++) if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                case (reg_n)
                    0:       exp_d = {32'h0, m_entry};
                    2:       exp_d = m_scratch;
                    3:       exp_d = (64'(m_wake_cnt) << 16) | 64'(m_boot_cnt);
                    default: exp_d = '0;
                endcase
            end
        end
    endtask

    // Entered and left at a negedge. Holds p_ready_i low for `hold` cycles after the
    // response appears, checking it stays put, then consumes it.
    task automatic send(input string tag, input logic [47:0] addr, input logic wr,
                        input logic [63:0] data, input logic [7:0] strb, input logic [3:0] amo,
                        input int hold);
        logic [63:0] exp_d;
        logic        exp_e;
        int          w;
        model_access(addr, wr, data, strb, amo, exp_d, exp_e);
        q_valid_i = 1'b1; q_addr_i = addr; q_write_i = wr; q_data_i = data;
        q_strb_i = strb; q_amo_i = amo; p_ready_i = 1'b0;
        w = 0;
        while (q_ready_o !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_q_ready_wait"}, 64'(w < 20), 64'd1);
        @(negedge clk);
        q_valid_i = 1'b0;
        check({tag, "_p_valid"}, 64'(p_valid_o), 64'd1);
        check({tag, "_q_ready_low"}, 64'(q_ready_o), 64'd0);
        check({tag, "_p_data"}, p_data_o, exp_d);
        check({tag, "_p_error"}, 64'(p_error_o), 64'(exp_e));
        msip_trace[0] = msip_o;
        msip_b_trace[0] = msip_b;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_p_valid"}, 64'(p_valid_o), 64'd1);
            check({tag, "_hold_q_ready"}, 64'(q_ready_o), 64'd0);
            check({tag, "_hold_p_data"}, p_data_o, exp_d);
            check({tag, "_hold_p_error"}, 64'(p_error_o), 64'(exp_e));
            if (i < 7) begin
                msip_trace[i+1] = msip_o;
                msip_b_trace[i+1] = msip_b;
            end
        end
        p_ready_i = 1'b1;
        @(negedge clk);
        p_ready_i = 1'b0;
        check({tag, "_p_valid_drop"}, 64'(p_valid_o), 64'd0);
        check({tag, "_q_ready_back"}, 64'(q_ready_o), 64'd1);
        check({tag, "_entry_point"}, 64'(entry_point_o), 64'(m_entry));
        check({tag, "_boot_valid"}, 64'(boot_valid_o), 64'(m_boot_valid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_d;
        logic        exp_e;
        int          hs1, hs2, w;
        logic [47:0] addr;
        int          sel;

        // Clock/reset
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check("rst_q_ready", 64'(q_ready_o), 64'd1);
        check("rst_p_valid", 64'(p_valid_o), 64'd0);
        check("rst_p_data", p_data_o, 64'd0);
        check("rst_p_error", 64'(p_error_o), 64'd0);
        check("rst_entry", 64'(entry_point_o), 64'd0);
        check("rst_boot_valid", 64'(boot_valid_o), 64'd0);
        check("rst_msip", 64'(msip_o), 64'd0);

        // Boot entry point with a stalled response
        send("boot_wr", BASE + 48'h00, 1'b1, 64'h0000_0000_8000_0000, 8'hFF, 4'd0, 3);
        check("boot_entry_const", 64'(entry_point_o), 64'h8000_0000);
        check("boot_valid_const", 64'(boot_valid_o), 64'd1);

        // Wake both cores; main instance pulses 1 cycle, second instance 4 cycles
        send("wake_wr", BASE + 48'h08, 1'b1, 64'd3, 8'hFF, 4'd0, 5);
        check("wake_msip_c0", 64'(msip_trace[0]), 64'd3);
        check("wake_msip_c1", 64'(msip_trace[1]), 64'd0);
        check("wake_b_msip_c0", 64'(msip_b_trace[0]), 64'd3);
        check("wake_b_msip_c3", 64'(msip_b_trace[3]), 64'd3);
        check("wake_b_msip_c4", 64'(msip_b_trace[4]), 64'd0);
        send("status_rd", BASE + 48'h18, 1'b0, 64'd0, 8'hFF, 4'd0, 0);
        check("status_const", p_data_o, 64'h0000_0000_0001_0001);

        // Partial strobe on BOOT_CONTROL
        send("boot_strb", BASE + 48'h00, 1'b1, 64'h0000_0000_AABB_CCDD, 8'h01, 4'd0, 1);
        check("boot_strb_const", 64'(entry_point_o), 64'h8000_00DD);
        send("boot_nostrb", BASE + 48'h00, 1'b1, 64'h0000_0000_1111_1111, 8'hF0, 4'd0, 0);

        // Decode and AMO errors
        send("oor_rd", BASE + 48'h20, 1'b0, 64'd0, 8'hFF, 4'd0, 1);
        send("amo_wr", BASE + 48'h10, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 4'd2, 1);
        send("scratch_rd0", BASE + 48'h10, 1'b0, 64'd0, 8'hFF, 4'd0, 0);
        check("scratch_unchanged", p_data_o, 64'd0);
        send("status_wr", BASE + 48'h18, 1'b1, 64'hFFFF, 8'hFF, 4'd0, 0);

        // Back-to-back SCRATCH write then read with p_ready_i tied high
        model_access(BASE + 48'h10, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'hFF, 4'd0, exp_d, exp_e);
        model_access(BASE + 48'h10, 1'b0, 64'd0, 8'hFF, 4'd0, exp_d, exp_e);
        q_valid_i = 1'b1; q_addr_i = BASE + 48'h10; q_write_i = 1'b1;
        q_data_i = 64'hDEAD_BEEF_0123_4567; q_strb_i = 8'hFF; q_amo_i = 4'd0; p_ready_i = 1'b1;
        hs1 = -1; hs2 = -1; w = 0;
        while (w < 10 && hs2 < 0) begin
            if (q_ready_o === 1'b1) begin
                if (hs1 < 0) hs1 = w;
                else hs2 = w;
            end
            @(negedge clk);
            w++;
            if (hs1 >= 0 && hs2 < 0 && q_write_i) begin
                q_write_i = 1'b0;
                q_data_i  = '0;
            end
        end
        q_valid_i = 1'b0;
        check("b2b_hs_seen", 64'(hs2 >= 0), 64'd1);
        check("b2b_hs_spacing", 64'(hs2 - hs1), 64'd2);
        check("b2b_p_valid", 64'(p_valid_o), 64'd1);
        check("b2b_p_data", p_data_o, exp_d);
        check("b2b_p_data_const", p_data_o, 64'hDEAD_BEEF_0123_4567);
        check("b2b_p_error", 64'(p_error_o), 64'(exp_e));
        @(negedge clk);
        p_ready_i = 1'b0;
        check("b2b_p_valid_drop", 64'(p_valid_o), 64'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            if (sel < 4) addr = BASE + 48'(sel * 8);
            else if (sel == 4) addr = BASE + 48'h20 + 48'(8 * $urandom_range(0, 3));
            else addr = {$urandom, 16'h0} | 48'h100;
            send("rand", addr, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom),
                 ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 8)) : 4'd0,
                 $urandom_range(0, 2));
        end

        // Reset while a response is pending and the 4-cycle pulse is running
        q_valid_i = 1'b1; q_addr_i = BASE + 48'h08; q_write_i = 1'b1;
        q_data_i = 64'd3; q_strb_i = 8'hFF; q_amo_i = 4'd0; p_ready_i = 1'b0;
        check("rstmid_q_ready_pre", 64'(q_ready_b), 64'd1);
        @(negedge clk);
        q_valid_i = 1'b0;
        check("rstmid_p_valid_pre", 64'(p_valid_b), 64'd1);
        @(negedge clk);
        check("rstmid_msip_pre", 64'(msip_b), 64'd3);
        check("rstmid_boot_valid_pre", 64'(boot_valid_b), 64'd1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("rstmid_p_valid", 64'(p_valid_b), 64'd0);
        check("rstmid_msip", 64'(msip_b), 64'd0);
        check("rstmid_boot_valid", 64'(boot_valid_b), 64'd0);
        check("rstmid_q_ready", 64'(q_ready_b), 64'd1);
        check("rstmid_entry", 64'(entry_point_b), 64'd0);
        check("rstmid_main_p_valid", 64'(p_valid_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
